// File: rtl/vga_sync_decoder.sv
// VGA sync sink: measures hsync/vsync timing, locks to a known mode,
// and recovers active-area pixel coordinates and colour.
module vga_sync_decoder #(
  parameter int HPIXELS     = 800,
  parameter int VLINES      = 521,
  parameter int HPULSE      = 96,
  parameter int VPULSE      = 2,
  parameter int HBP         = 144,
  parameter int HFP         = 784,
  parameter int VBP         = 31,
  parameter int VFP         = 511,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  output logic       locked,
  output logic       frame_start,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [3:0] pix_r,
  output logic [3:0] pix_g,
  output logic [3:0] pix_b,
  output logic [9:0] meas_hpixels,
  output logic [9:0] meas_hpulse,
  output logic [9:0] meas_vlines,
  output logic [9:0] meas_vpulse,
  output logic [7:0] err_cnt
);

  localparam logic [9:0] CMAX = 10'h3FF;
  localparam logic [9:0] HP   = 10'(HPIXELS);
  localparam logic [9:0] VL   = 10'(VLINES);
  localparam logic [9:0] HPW  = 10'(HPULSE);
  localparam logic [9:0] VPW  = 10'(VPULSE);
  localparam logic [9:0] HB   = 10'(HBP);
  localparam logic [9:0] HF   = 10'(HFP);
  localparam logic [9:0] VB   = 10'(VBP);
  localparam logic [9:0] VF   = 10'(VFP);
  localparam logic [3:0] LF   = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } state_t;

  state_t     state;
  logic [3:0] good_cnt;

  logic       s1_hs;
  logic       s1_vs;
  logic       hs_d;
  logic       vs_d;
  logic [3:0] s1_r;
  logic [3:0] s1_g;
  logic [3:0] s1_b;

  logic [9:0] hcnt;
  logic [9:0] vpos;
  logic       frame_bad;

  logic       line_start;
  logic       hs_rise;
  logic       vs_fall;
  logic       vs_rise;
  logic       fs_ev;
  logic       vr_ev;
  logic [9:0] hpos;
  logic [9:0] hnext;
  logic [9:0] vinc;
  logic       line_bad;
  logic       vl_bad;
  logic       vp_bad;
  logic       fbad_now;
  logic       timeout;
  logic       de_n;

  // History regs reset high so release from reset never fakes an edge.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      s1_hs <= 1'b1;
      s1_vs <= 1'b1;
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      s1_r  <= '0;
      s1_g  <= '0;
      s1_b  <= '0;
    end else begin
      s1_hs <= hsync;
      s1_vs <= vsync;
      hs_d  <= s1_hs;
      vs_d  <= s1_vs;
      s1_r  <= red;
      s1_g  <= green;
      s1_b  <= blue;
    end
  end

  assign line_start = hs_d & ~s1_hs;
  assign hs_rise    = ~hs_d & s1_hs;
  assign vs_fall    = vs_d & ~s1_vs;
  assign vs_rise    = ~vs_d & s1_vs;
  assign fs_ev      = line_start & vs_fall;
  assign vr_ev      = line_start & vs_rise;

  assign hpos  = line_start ? '0 : hcnt;
  assign hnext = (hpos == CMAX) ? CMAX : hpos + 10'd1;
  assign vinc  = (vpos == CMAX) ? CMAX : vpos + 10'd1;

  assign line_bad = (line_start && hcnt != HP)
                  || (hs_rise && hpos != HPW);
  assign vl_bad   = fs_ev && (vinc != VL);
  assign vp_bad   = vr_ev && (vinc != VPW);
  assign fbad_now = frame_bad | line_bad | vl_bad | vp_bad;

  // A line_start on the saturated count is sync returning, not a timeout.
  assign timeout = (hcnt == CMAX) && !line_start;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hcnt         <= '0;
      vpos         <= '0;
      frame_bad    <= 1'b0;
      meas_hpixels <= '0;
      meas_hpulse  <= '0;
      meas_vlines  <= '0;
      meas_vpulse  <= '0;
    end else begin
      hcnt      <= hnext;
      frame_bad <= fs_ev ? 1'b0 : fbad_now;
      if (line_start) begin
        meas_hpixels <= hcnt;
        vpos         <= vs_fall ? '0 : vinc;
      end
      if (hs_rise)
        meas_hpulse <= hpos;
      if (fs_ev)
        meas_vlines <= vinc;
      if (vr_ev)
        meas_vpulse <= vinc;
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state    <= SEARCH;
      good_cnt <= '0;
      err_cnt  <= '0;
    end else if (timeout) begin
      state    <= SEARCH;
      good_cnt <= '0;
      if (state == LOCKED && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end else begin
      unique case (state)
        SEARCH: begin
          if (fs_ev) begin
            state    <= TRACK;
            good_cnt <= '0;
          end
        end
        TRACK: begin
          if (fs_ev) begin
            if (fbad_now) begin
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 >= LF)
                state <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (line_bad || (fs_ev && fbad_now)) begin
            state    <= TRACK;
            good_cnt <= '0;
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
          end
        end
        default: begin
          state    <= SEARCH;
          good_cnt <= '0;
        end
      endcase
    end
  end

  assign locked = (state == LOCKED);

  assign de_n = locked
             && hpos >= HB && hpos < HF
             && vpos >= VB && vpos < VF;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      frame_start <= 1'b0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
    end else begin
      frame_start <= fs_ev;
      de          <= de_n;
      x           <= de_n ? hpos - HB : '0;
      y           <= de_n ? vpos - VB : '0;
      pix_r       <= de_n ? s1_r : '0;
      pix_g       <= de_n ? s1_g : '0;
      pix_b       <= de_n ? s1_b : '0;
    end
  end

endmodule
